// File: rtl/plaintext_drawer.sv
// Responder for the draw_plaintext / done_drawing_plaintext handshake: latches a
// plaintext word and streams its bytes, MSB first, into character memory.
module plaintext_drawer #(
    parameter int NUM_CHARS = 16,
    parameter int ADDR_W    = 12,
    parameter int BASE_ADDR = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   draw_plaintext,
    input  logic [8*NUM_CHARS-1:0] plaintext_to_draw,
    output logic                   done_drawing_plaintext,
    output logic                   busy,
    output logic                   char_valid,
    input  logic                   char_ready,
    output logic [ADDR_W-1:0]      char_addr,
    output logic [7:0]             char_data
);

    localparam int W     = 8 * NUM_CHARS;
    localparam int IDX_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHARS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     shadow;

    // The shadow word shifts left by one byte per accepted write, so the next
    // byte to present always sits just below the top byte.
    always_ff @(posedge clk) begin
        // NOTE: all state is updated with non-blocking assignments so every
        // register samples pre-edge values; outputs are registers, never decodes.
        if (!reset_n) begin
            state                  <= IDLE;
            idx                    <= '0;
            shadow                 <= '0;
            done_drawing_plaintext <= 1'b0;
            busy                   <= 1'b0;
            char_valid             <= 1'b0;
            char_addr              <= '0;
            char_data              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (draw_plaintext) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    shadow     <= plaintext_to_draw;
                    idx        <= '0;
                    char_valid <= 1'b1;
                    char_addr  <= BASE;
                    char_data  <= plaintext_to_draw[W-1 -: 8];
                    state      <= WRITE;
                end
                WRITE: begin
                    if (char_valid && char_ready) begin
                        if (idx == LAST_IDX) begin
                            char_valid             <= 1'b0;
                            done_drawing_plaintext <= 1'b1;
                            state                  <= DONE;
                        end else begin
                            idx       <= idx + 1'b1;
                            char_addr <= char_addr + 1'b1;
                            char_data <= shadow[W-9 -: 8];
                            shadow    <= shadow << 8;
                        end
                    end
                end
                DONE: begin
                    // A fresh draw needs draw_plaintext to go low first.
                    if (!draw_plaintext) begin
                        done_drawing_plaintext <= 1'b0;
                        busy                   <= 1'b0;
                        state                  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_plaintext_drawer.sv
// Scoreboard bench for plaintext_drawer: one instance at BASE_ADDR 0 and one at
// 4090 (address wrap) share all stimulus; each has its own expected-write queue.
module tb_plaintext_drawer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         draw;
    logic [127:0] pt;
    logic         ready;

    logic        done0, busy0, valid0;
    logic [11:0] addr0;
    logic [7:0]  data0;
    logic        done1, busy1, valid1;
    logic [11:0] addr1;
    logic [7:0]  data1;

    int n_tests = 0;
    int n_fail  = 0;
    int acc0    = 0;
    int acc1    = 0;

    logic [19:0] q0[$];
    logic [19:0] q1[$];

    always #5 clk = ~clk;

    plaintext_drawer #(.NUM_CHARS(16), .ADDR_W(12), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .draw_plaintext(draw), .plaintext_to_draw(pt),
        .done_drawing_plaintext(done0), .busy(busy0), .char_valid(valid0),
        .char_ready(ready), .char_addr(addr0), .char_data(data0)
    );

    plaintext_drawer #(.NUM_CHARS(16), .ADDR_W(12), .BASE_ADDR(4090)) dut1 (
        .clk(clk), .reset_n(reset_n), .draw_plaintext(draw), .plaintext_to_draw(pt),
        .done_drawing_plaintext(done1), .busy(busy1), .char_valid(valid1),
        .char_ready(ready), .char_addr(addr1), .char_data(data1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [127:0] word);
        logic [11:0] a0;
        logic [11:0] a1;
        logic [7:0]  b;
        for (int i = 0; i < 16; i++) begin
            a0 = 12'(i);
            a1 = 12'(4090 + i);
            b  = word[8*(15-i) +: 8];
            q0.push_back({a0, b});
            q1.push_back({a1, b});
        end
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 200; n++) begin
            if (done0 && done1) break;
            tick();
        end
        check(tag, {31'd0, done0 & done1}, 32'd1);
    endtask

    // Monitors sample on the falling edge; a handshake seen here completes on
    // the following rising edge because inputs only change just after posedge.
    logic        stall0 = 1'b0, stall1 = 1'b0;
    logic [19:0] hold0, hold1;

    always @(negedge clk) begin
        logic [19:0] e;
        if (!reset_n) stall0 = 1'b0;
        else begin
            if (stall0) check("stall_stable0", {11'd0, valid0, addr0, data0}, {11'd0, 1'b1, hold0});
            if (valid0 && ready) begin
                if (q0.size() == 0) check("extra_write0", 32'(q0.size()), 32'd1);
                else begin
                    e = q0.pop_front();
                    check("write0", {12'd0, addr0, data0}, {12'd0, e});
                end
                acc0++;
            end
            stall0 = valid0 && !ready;
            hold0  = {addr0, data0};
        end
    end

    always @(negedge clk) begin
        logic [19:0] e;
        if (!reset_n) stall1 = 1'b0;
        else begin
            if (stall1) check("stall_stable1", {11'd0, valid1, addr1, data1}, {11'd0, 1'b1, hold1});
            if (valid1 && ready) begin
                if (q1.size() == 0) check("extra_write1", 32'(q1.size()), 32'd1);
                else begin
                    e = q1.pop_front();
                    check("write1", {12'd0, addr1, data1}, {12'd0, e});
                end
                acc1++;
            end
            stall1 = valid1 && !ready;
            hold1  = {addr1, data1};
        end
    end

    initial begin
        logic [127:0] hello;
        logic [127:0] second;
        logic         pat[4];
        int           start;
        hello  = "HELLO WORLD 2021";
        second = "Codebreaker#0123";
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        reset_n = 1'b0; draw = 1'b0; pt = '0; ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", {31'd0, valid0}, 32'd0);
        check("rst_done",  {31'd0, done0},  32'd0);
        check("rst_busy",  {31'd0, busy0},  32'd0);
        check("rst_addr_data", {12'd0, addr0, data0}, 32'd0);
        check("rst_addr1", {20'd0, addr1}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Full draw with ready high: latency and hold of done
        pt = hello; push_expected(hello); start = acc0;
        draw = 1'b1;
        tick();                                  // edge N: request seen
        check("load_valid", {31'd0, valid0}, 32'd0);
        check("load_busy",  {31'd0, busy0},  32'd1);
        tick();
        check("first_valid", {31'd0, valid0}, 32'd1);
        check("first_byte", {12'd0, addr0, data0}, {12'd0, 12'd0, 8'h48});
        repeat (15) tick();                      // N+16
        check("done_not_early", {31'd0, done0}, 32'd0);
        tick();                                  // N+17
        check("done_at_18", {31'd0, done0}, 32'd1);
        check("done_valid_low", {31'd0, valid0}, 32'd0);
        check("count_t1", 32'(acc0 - start), 32'd16);
        repeat (3) tick();
        check("done_held", {30'd0, done0, busy0}, 32'd3);
        draw = 1'b0;
        tick();
        check("idle_after", {30'd0, done0, busy0}, 32'd0);
        tick();

        // Stalls on char_ready
        pt = second; push_expected(second); start = acc0;
        draw = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            ready = pat[cyc % 4];
            tick();
            if (done0) break;
        end
        ready = 1'b1;
        check("stall_done", {31'd0, done0}, 32'd1);
        check("count_stall", 32'(acc0 - start), 32'd16);
        draw = 1'b0;
        repeat (2) tick();

        // Input changed after LOAD must not affect the draw
        pt = hello; push_expected(hello);
        draw = 1'b1;
        tick();                                  // LOAD
        tick();                                  // LOAD has sampled pt
        pt = {16{8'h5A}};
        wait_done("latch_done");
        draw = 1'b0;
        repeat (2) tick();

        // Reset after the 5th accepted write
        pt = second; push_expected(second); start = acc0;
        draw = 1'b1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (acc0 - start == 5) break;
        end
        check("five_writes", 32'(acc0 - start), 32'd5);
        reset_n = 1'b0; draw = 1'b0;
        tick();
        check("midrst_state", {29'd0, valid0, done0, busy0}, 32'd0);
        check("midrst_state1", {29'd0, valid1, done1, busy1}, 32'd0);
        q0.delete(); q1.delete();
        reset_n = 1'b1;
        tick();
        pt = hello; push_expected(hello); start = acc0;
        draw = 1'b1;
        wait_done("restart_done");
        check("count_restart", 32'(acc0 - start), 32'd16);
        draw = 1'b0;
        repeat (2) tick();

        // One-cycle request pulse
        pt = second; push_expected(second); start = acc0;
        draw = 1'b1;
        tick();
        draw = 1'b0;
        wait_done("pulse_done");
        tick();
        check("pulse_done_1cyc", {30'd0, done0, busy0}, 32'd0);
        check("count_pulse", 32'(acc0 - start), 32'd16);
        repeat (3) tick();
        check("pulse_stays_idle", {30'd0, busy0, valid0}, 32'd0);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("acc_match", 32'(acc1), 32'(acc0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
